// File: rtl/sudoku_pkg.sv
// Shared geometry, unit numbering and FSM state for the sudoku grid checker.
package sudoku_pkg;
  localparam int CELL_W    = 4;
  localparam int N         = 9;
  localparam int GRID_W    = 324;
  localparam int NUM_UNITS = 27;

  localparam logic [4:0] NO_UNIT = 5'd31;
  localparam logic [4:0] ROW     = 5'd0;
  localparam logic [4:0] COL     = 5'd9;
  localparam logic [4:0] BOX     = 5'd18;

  typedef enum logic {IDLE, CHECK} state_e;

  // Bit offset of the k-th cell of unit u inside the flattened grid.
  function automatic logic [8:0] cell_base(input logic [4:0] u, input int k);
    int r, c, b;
    if (u < COL) begin
      r = int'(u);
      c = k;
    end else if (u < BOX) begin
      r = k;
      c = int'(u) - int'(COL);
    end else begin
      b = int'(u) - int'(BOX);
      r = 3 * (b / 3) + k / 3;
      c = 3 * (b % 3) + k % 3;
    end
    return 9'(36 * r + 4 * c);
  endfunction
endpackage

// File: rtl/sudoku_unit_check.sv
// Combinational evaluation of one 9-cell unit: duplicate, illegal digit and empty flags.
module sudoku_unit_check
  import sudoku_pkg::*;
(
  input  logic [N-1:0][CELL_W-1:0] cells,
  output logic                     dup,
  output logic                     illegal,
  output logic                     empty
);
  logic [N-1:0] seen;

  always_comb begin
    seen    = '0;
    dup     = 1'b0;
    illegal = 1'b0;
    empty   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cells[k] == 4'd0) begin
        empty = 1'b1;
      end else if (cells[k] > 4'd9) begin
        illegal = 1'b1;
      end else begin
        if (seen[cells[k] - 4'd1]) dup = 1'b1;
        seen[cells[k] - 4'd1] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sudoku_grid_checker.sv
// Latches a grid on start and checks one row/column/box per clock for 27 clocks.
module sudoku_grid_checker
  import sudoku_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:GRID_W-1] sudoku,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              has_empty,
  output logic              has_conflict,
  output logic [4:0]        bad_unit
);
  state_e            state_q, state_d;
  logic [0:GRID_W-1] grid_q, grid_d;
  logic [4:0]        u_q, u_d;
  logic              acc_empty_q, acc_empty_d;
  logic              acc_conflict_q, acc_conflict_d;
  logic [4:0]        acc_bad_q, acc_bad_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              has_empty_q, has_empty_d;
  logic              has_conflict_q, has_conflict_d;
  logic [4:0]        bad_unit_q, bad_unit_d;

  logic [N-1:0][CELL_W-1:0] unit_cells;
  logic                     u_dup, u_illegal, u_empty, u_fail;
  logic                     empty_n, conflict_n;
  logic [4:0]               bad_n;

  always_comb begin
    unit_cells = '0;
    for (int k = 0; k < N; k++) begin
      unit_cells[k] = grid_q[cell_base(u_q, k) +: CELL_W];
    end
  end

  sudoku_unit_check u_check (
    .cells   (unit_cells),
    .dup     (u_dup),
    .illegal (u_illegal),
    .empty   (u_empty)
  );

  // Accumulators including the unit currently being evaluated.
  assign u_fail     = u_dup | u_illegal;
  assign empty_n    = acc_empty_q | u_empty;
  assign conflict_n = acc_conflict_q | u_fail;
  assign bad_n      = (acc_bad_q == NO_UNIT && u_fail) ? u_q : acc_bad_q;

  always_comb begin
    state_d        = state_q;
    grid_d         = grid_q;
    u_d            = u_q;
    acc_empty_d    = acc_empty_q;
    acc_conflict_d = acc_conflict_q;
    acc_bad_d      = acc_bad_q;
    done_d         = 1'b0;
    valid_d        = valid_q;
    has_empty_d    = has_empty_q;
    has_conflict_d = has_conflict_q;
    bad_unit_d     = bad_unit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          grid_d         = sudoku;
          acc_empty_d    = 1'b0;
          acc_conflict_d = 1'b0;
          acc_bad_d      = NO_UNIT;
          u_d            = 5'd0;
          state_d        = CHECK;
        end
      end
      CHECK: begin
        acc_empty_d    = empty_n;
        acc_conflict_d = conflict_n;
        acc_bad_d      = bad_n;
        if (u_q == 5'(NUM_UNITS - 1)) begin
          state_d        = IDLE;
          u_d            = 5'd0;
          done_d         = 1'b1;
          valid_d        = !empty_n && !conflict_n;
          has_empty_d    = empty_n;
          has_conflict_d = conflict_n;
          bad_unit_d     = bad_n;
        end else begin
          u_d = u_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grid_q         <= '0;
      u_q            <= 5'd0;
      acc_empty_q    <= 1'b0;
      acc_conflict_q <= 1'b0;
      acc_bad_q      <= NO_UNIT;
      done_q         <= 1'b0;
      valid_q        <= 1'b0;
      has_empty_q    <= 1'b0;
      has_conflict_q <= 1'b0;
      bad_unit_q     <= NO_UNIT;
    end else begin
      state_q        <= state_d;
      grid_q         <= grid_d;
      u_q            <= u_d;
      acc_empty_q    <= acc_empty_d;
      acc_conflict_q <= acc_conflict_d;
      acc_bad_q      <= acc_bad_d;
      done_q         <= done_d;
      valid_q        <= valid_d;
      has_empty_q    <= has_empty_d;
      has_conflict_q <= has_conflict_d;
      bad_unit_q     <= bad_unit_d;
    end
  end

  assign busy         = (state_q == CHECK);
  assign done         = done_q;
  assign valid        = valid_q;
  assign has_empty    = has_empty_q;
  assign has_conflict = has_conflict_q;
  assign bad_unit     = bad_unit_q;
endmodule
